// File: rtl/sram_fifo_ctrl_pkg.sv
// sram_fifo_ctrl_pkg: shared state encoding, port indices and default sizes
package sram_fifo_ctrl_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int DEPTH_DEF  = 1024;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RD_WAIT,
        ST_ACK,
        ST_SETTLE
    } state_t;

endpackage

// File: rtl/sram_fifo_ctrl_fifo_ram.sv
// sram_fifo_ctrl_fifo_ram: simple dual-port buffer, one write port, one registered read port
module sram_fifo_ctrl_fifo_ram
    import sram_fifo_ctrl_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  logic [DATA_W-1:0]        i_wdata,
    input  logic                     i_re,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    output logic [DATA_W-1:0]        o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    // Synchronous write and one-cycle registered read; no reset so it maps onto block RAM
    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
        if (i_re) r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/sram_fifo_ctrl.sv
// sram_fifo_ctrl: two-port shared word FIFO on the request/hint handshake, one access at a time
module sram_fifo_ctrl
    import sram_fifo_ctrl_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              a_read,
    input  logic              a_write,
    input  logic [DATA_W-1:0] a_data_in,
    output logic [DATA_W-1:0] a_data_out,
    output logic              a_hint,
    input  logic              b_read,
    input  logic              b_write,
    input  logic [DATA_W-1:0] b_data_in,
    output logic [DATA_W-1:0] b_data_out,
    output logic              b_hint,
    output logic              full,
    output logic              empty,
    output logic [CNT_W-1:0]  count
);

    localparam int AW = $clog2(DEPTH);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [AW-1:0]     r_wptr;
    logic [AW-1:0]     r_rptr;
    logic [CNT_W-1:0]  r_count;
    logic [CNT_W-1:0]  w_count_nxt;
    logic              r_full;
    logic              r_empty;
    logic              r_last;
    logic              r_port;
    logic [DATA_W-1:0] r_a_dout;
    logic [DATA_W-1:0] r_b_dout;
    logic [DATA_W-1:0] w_rdata;
    logic [DATA_W-1:0] w_wdata;
    logic              w_a_wr;
    logic              w_a_rd;
    logic              w_b_wr;
    logic              w_b_rd;
    logic              w_a_elig;
    logic              w_b_elig;
    logic              w_gnt;
    logic              w_port;
    logic              w_wr;

    // Eligibility (a port's write beats its read only when the write can proceed), round-robin grant, next state
    always_comb begin
        w_a_wr      = a_write && !r_full;
        w_a_rd      = a_read && !r_empty;
        w_b_wr      = b_write && !r_full;
        w_b_rd      = b_read && !r_empty;
        w_a_elig    = w_a_wr || w_a_rd;
        w_b_elig    = w_b_wr || w_b_rd;
        w_gnt       = (r_state == ST_IDLE) && !clear && (w_a_elig || w_b_elig);
        w_port      = (w_a_elig && w_b_elig) ? ~r_last : (w_a_elig ? PORT_A : PORT_B);
        w_wr        = (w_port == PORT_A) ? w_a_wr : w_b_wr;
        w_wdata     = (w_port == PORT_A) ? a_data_in : b_data_in;
        w_count_nxt = clear ? '0 : !w_gnt ? r_count : w_wr ? r_count + 1'b1 : r_count - 1'b1;
        w_state_nxt = r_state;
        if (clear)
            w_state_nxt = ST_IDLE;
        else
            case (r_state)
                ST_IDLE:    w_state_nxt = !w_gnt ? ST_IDLE : w_wr ? ST_ACK : ST_RD_WAIT;
                ST_RD_WAIT: w_state_nxt = ST_ACK;
                ST_ACK:     w_state_nxt = ST_SETTLE;
                default:    w_state_nxt = ST_IDLE;
            endcase
        a_hint = (r_state == ST_ACK) && (r_port == PORT_A);
        b_hint = (r_state == ST_ACK) && (r_port == PORT_B);
    end

    // State register; async reset so a reset mid-ACK drops the hint immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Pointers, occupancy flags, arbitration memory and per-port read data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
            r_last   <= PORT_B;
            r_port   <= PORT_A;
            r_a_dout <= '0;
            r_b_dout <= '0;
        end else begin
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == CNT_W'(DEPTH));
            r_empty <= (w_count_nxt == '0);
            if (clear) begin
                r_wptr <= '0;
                r_rptr <= '0;
            end else if (w_gnt) begin
                r_last <= w_port;
                r_port <= w_port;
                if (w_wr) r_wptr <= r_wptr + 1'b1;
                else      r_rptr <= r_rptr + 1'b1;
            end
            if (!clear && r_state == ST_RD_WAIT) begin
                if (r_port == PORT_A) r_a_dout <= w_rdata;
                else                  r_b_dout <= w_rdata;
            end
        end
    end

    sram_fifo_ctrl_fifo_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo_ram (
        .clk     (clk),
        .i_we    (w_gnt && w_wr),
        .i_waddr (r_wptr),
        .i_wdata (w_wdata),
        .i_re    (w_gnt && !w_wr),
        .i_raddr (r_rptr),
        .o_rdata (w_rdata)
    );

    assign a_data_out = r_a_dout;
    assign b_data_out = r_b_dout;
    assign full       = r_full;
    assign empty      = r_empty;
    assign count      = r_count;

endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// tb_sram_fifo_ctrl: directed self-checking bench for the two-port shared FIFO controller
module tb_sram_fifo_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clear = 1'b0;
    logic        a_read = 1'b0;
    logic        a_write = 1'b0;
    logic        b_read = 1'b0;
    logic        b_write = 1'b0;
    logic [15:0] a_data_in = '0;
    logic [15:0] b_data_in = '0;
    logic [15:0] a_data_out;
    logic [15:0] b_data_out;
    logic        a_hint;
    logic        b_hint;
    logic        full;
    logic        empty;
    logic [10:0] count;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    sram_fifo_ctrl #(
        .DATA_W (16),
        .DEPTH  (1024),
        .CNT_W  (11)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear),
        .a_read     (a_read),
        .a_write    (a_write),
        .a_data_in  (a_data_in),
        .a_data_out (a_data_out),
        .a_hint     (a_hint),
        .b_read     (b_read),
        .b_write    (b_write),
        .b_data_in  (b_data_in),
        .b_data_out (b_data_out),
        .b_hint     (b_hint),
        .full       (full),
        .empty      (empty),
        .count      (count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Waits up to limit falling edges for the port's hint; lat = edges waited, -1 on timeout
    task automatic wait_hint(input bit port, input int limit, output int lat);
        lat = -1;
        for (int i = 1; i <= limit; i++) begin
            @(negedge clk);
            if (port ? b_hint : a_hint) begin
                lat = i;
                break;
            end
        end
    endtask

    // One complete access from IDLE; returns back in IDLE, h2 = hint one cycle after the pulse
    task automatic op(input bit port, input bit wr, input logic [15:0] d, output int lat, output logic h2);
        if (port) begin
            b_write = wr; b_read = !wr; b_data_in = d;
        end else begin
            a_write = wr; a_read = !wr; a_data_in = d;
        end
        wait_hint(port, 20, lat);
        if (port) begin
            b_write = 1'b0; b_read = 1'b0;
        end else begin
            a_write = 1'b0; a_read = 1'b0;
        end
        @(negedge clk);
        h2 = port ? b_hint : a_hint;
        @(negedge clk);
    endtask

    initial begin
        int          lat;
        int          bad;
        int          hints;
        int          nh;
        int          maxc;
        int          ht [4];
        logic        hp [4];
        logic [15:0] hd [4];
        logic        h2;
        logic [15:0] pat [3];
        pat[0] = 16'h6604; pat[1] = 16'h0004; pat[2] = 16'hAABB;
        for (int i = 0; i < 4; i++) begin
            ht[i] = 0; hp[i] = 1'b0; hd[i] = '0;
        end

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_a_hint", a_hint, 0);
        chk("rst_b_hint", b_hint, 0);
        chk("rst_a_dout", a_data_out, 0);
        chk("rst_b_dout", b_data_out, 0);
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic order: A pushes three, B pops three
        for (int i = 0; i < 3; i++) begin
            op(1'b0, 1'b1, pat[i], lat, h2);
            chk("basic_push_lat", lat, 1);
            chk("basic_push_pulse", h2, 0);
            chk("basic_push_count", count, i + 1);
        end
        chk("basic_not_empty", empty, 0);
        for (int i = 0; i < 3; i++) begin
            op(1'b1, 1'b0, 16'h0, lat, h2);
            chk("basic_pop_lat", lat, 2);
            chk("basic_pop_pulse", h2, 0);
            chk("basic_pop_data", b_data_out, pat[i]);
            chk("basic_pop_count", count, 2 - i);
        end
        chk("basic_empty", empty, 1);

        // Full boundary
        bad = 0;
        for (int i = 0; i < 1024; i++) begin
            op(1'b1, 1'b1, 16'(i), lat, h2);
            if (lat != 1) bad++;
        end
        chk("fill_lat_errs", bad, 0);
        chk("fill_full", full, 1);
        chk("fill_count", count, 1024);
        a_write = 1'b1; a_data_in = 16'hBEEF;
        hints = 0;
        repeat (10) begin
            @(negedge clk);
            if (a_hint) hints++;
        end
        chk("full_push_nohint", hints, 0);
        a_read = 1'b1;
        wait_hint(1'b0, 20, lat);
        chk("full_pop_lat", lat, 2);
        chk("full_pop_data", a_data_out, 16'h0000);
        chk("full_pop_full", full, 0);
        chk("full_pop_count", count, 1023);
        a_read = 1'b0;
        wait_hint(1'b0, 20, lat);
        chk("full_pending_push_lat", lat, 3);
        chk("full_again", full, 1);
        chk("full_again_count", count, 1024);
        a_write = 1'b0;
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        chk("clear_count", count, 0);
        chk("clear_empty", empty, 1);
        chk("clear_full", full, 0);

        // Empty pending: read held while empty, then B pushes
        a_read = 1'b1;
        hints = 0;
        repeat (50) begin
            @(negedge clk);
            if (a_hint) hints++;
        end
        chk("empty_pend_nohint", hints, 0);
        op(1'b1, 1'b1, 16'h1234, lat, h2);
        chk("empty_pend_push_lat", lat, 1);
        wait_hint(1'b0, 20, lat);
        chk("empty_pend_pop_lat", lat, 2);
        chk("empty_pend_data", a_data_out, 16'h1234);
        a_read = 1'b0;
        repeat (2) @(negedge clk);
        chk("empty_pend_count", count, 0);
        chk("empty_pend_empty", empty, 1);

        // Contention: A write and B read held together from count=1
        op(1'b1, 1'b1, 16'h5555, lat, h2);
        chk("cont_setup_count", count, 1);
        a_write = 1'b1; a_data_in = 16'hC0DE; b_read = 1'b1;
        nh = 0;
        maxc = 0;
        for (int t = 1; t <= 60 && nh < 4; t++) begin
            @(negedge clk);
            if (int'(count) > maxc) maxc = int'(count);
            if (a_hint || b_hint) begin
                ht[nh] = t; hp[nh] = b_hint; hd[nh] = b_data_out;
                nh++;
            end
        end
        a_write = 1'b0; b_read = 1'b0;
        chk("cont_grants", nh, 4);
        chk("cont_t0", ht[0], 1);
        chk("cont_t1", ht[1], 5);
        chk("cont_t2", ht[2], 8);
        chk("cont_t3", ht[3], 12);
        chk("cont_p0", hp[0], 0);
        chk("cont_p1", hp[1], 1);
        chk("cont_p2", hp[2], 0);
        chk("cont_p3", hp[3], 1);
        chk("cont_d1", hd[1], 16'h5555);
        chk("cont_d3", hd[3], 16'hC0DE);
        chk("cont_max_count", maxc, 2);
        chk("cont_end_count", count, 1);
        repeat (2) @(negedge clk);
        op(1'b1, 1'b0, 16'h0, lat, h2);
        chk("cont_drain_data", b_data_out, 16'hC0DE);
        chk("cont_drain_count", count, 0);

        // Wrap-around: 1500 push/pop pairs
        bad = 0;
        for (int i = 0; i < 1500; i++) begin
            op(1'b0, 1'b1, 16'(i), lat, h2);
            if (lat != 1) bad++;
            op(1'b1, 1'b0, 16'h0, lat, h2);
            if (lat != 2 || b_data_out !== 16'(i)) bad++;
        end
        chk("wrap_errs", bad, 0);
        chk("wrap_count", count, 0);
        chk("wrap_empty", empty, 1);

        // clear while a read sits in RD_WAIT
        op(1'b0, 1'b1, 16'h7777, lat, h2);
        op(1'b0, 1'b1, 16'h8888, lat, h2);
        chk("clr_setup_count", count, 2);
        b_read = 1'b1;
        @(negedge clk);
        chk("clr_rdwait_count", count, 1);
        clear = 1'b1; b_read = 1'b0;
        @(negedge clk);
        clear = 1'b0;
        hints = 0;
        repeat (8) begin
            @(negedge clk);
            if (b_hint) hints++;
        end
        chk("clr_nohint", hints, 0);
        chk("clr_count", count, 0);
        chk("clr_empty", empty, 1);
        chk("clr_dout_kept", b_data_out, 16'h05DB);
        op(1'b0, 1'b1, 16'h4242, lat, h2);
        op(1'b1, 1'b0, 16'h0, lat, h2);
        chk("clr_after_lat", lat, 2);
        chk("clr_after_data", b_data_out, 16'h4242);

        // Reset asserted mid-ACK
        a_write = 1'b1; a_data_in = 16'h9999;
        @(negedge clk);
        chk("rst_mid_hint_before", a_hint, 1);
        chk("rst_mid_count_before", count, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_mid_a_hint", a_hint, 0);
        chk("rst_mid_b_hint", b_hint, 0);
        chk("rst_mid_a_dout", a_data_out, 0);
        chk("rst_mid_b_dout", b_data_out, 0);
        chk("rst_mid_count", count, 0);
        chk("rst_mid_empty", empty, 1);
        chk("rst_mid_full", full, 0);
        a_write = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
